// File: rtl/cb_config_loader.sv
// rtl/cb_config_loader.sv - connection-block tile configuration loader with sync/pad/XOR frame checks
//
// Ports:
//   clb_clk     in   1   clock
//   rst         in   1   asynchronous active-low reset
//   cfg_data    in   8   configuration byte
//   cfg_valid   in   1   cfg_data is valid
//   cfg_ready   out  1   a byte is accepted on this edge when cfg_valid is high (registered)
//   cfg_abort   in   1   discard the frame in progress (LOAD/CHECK only)
//   prog        out  69  active tile configuration word (registered)
//   tile_rst_n  out  1   active-low reset to the tile CLB (registered)
//   cfg_busy    out  1   frame in progress or post-commit hold running
//   cfg_done    out  1   one-cycle pulse when a commit completes
//   cfg_err     out  1   sticky frame error, cleared by the next sync byte
module cb_config_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         HOLD_CYCLES = 2
) (
    input  logic        clb_clk,
    input  logic        rst,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_abort,
    output logic [68:0] prog,
    output logic        tile_rst_n,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  hold_q, hold_d;
    // 72 bits so the padding bits of payload byte 9 land in [71:69] and can be checked at CHECK.
    logic [71:0] shadow_q, shadow_d;
    logic [7:0]  sum_q, sum_d;
    logic [68:0] prog_q, prog_d;
    logic        ready_q, ready_d;
    logic        tile_rst_n_q, tile_rst_n_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        xfer;
    logic        pad_bad;

    assign xfer    = cfg_valid & ready_q;
    assign pad_bad = |shadow_q[71:69];

    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            shadow_q     <= '0;
            sum_q        <= '0;
            prog_q       <= '0;
            ready_q      <= 1'b0;
            tile_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            shadow_q     <= shadow_d;
            sum_q        <= sum_d;
            prog_q       <= prog_d;
            ready_q      <= ready_d;
            tile_rst_n_q <= tile_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        shadow_d     = shadow_q;
        sum_d        = sum_q;
        prog_d       = prog_q;
        err_d        = err_q;
        done_d       = 1'b0;
        ready_d      = 1'b1;
        tile_rst_n_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (xfer && cfg_data == SYNC_BYTE) begin
                    state_d  = ST_LOAD;
                    err_d    = 1'b0;
                    shadow_d = '0;
                    sum_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    for (int i = 0; i < 9; i++) begin
                        if (cnt_q == 4'(i)) begin
                            shadow_d[i*8 +: 8] = cfg_data;
                        end
                    end
                    sum_d = sum_q ^ cfg_data;
                    if (cnt_q == 4'd8) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (cfg_data == sum_q && !pad_bad) begin
                        // Commit: prog and the tile reset change on the same edge.
                        prog_d       = shadow_q[68:0];
                        state_d      = ST_HOLD;
                        hold_d       = '0;
                        ready_d      = 1'b0;
                        tile_rst_n_d = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                ready_d      = 1'b0;
                tile_rst_n_d = 1'b0;
                // The commit edge itself is the first low cycle, so the exit comes after HOLD_CYCLES-1 more.
                if (hold_q == 4'(HOLD_CYCLES - 1)) begin
                    state_d      = ST_IDLE;
                    ready_d      = 1'b1;
                    tile_rst_n_d = 1'b1;
                    done_d       = 1'b1;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_ready  = ready_q;
    assign prog       = prog_q;
    assign tile_rst_n = tile_rst_n_q;
    assign cfg_busy   = (state_q != ST_IDLE);
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_cb_config_loader.sv
// tb/tb_cb_config_loader.sv - randomized frame-level bench for cb_config_loader (HOLD_CYCLES 2 and 5)
module tb_cb_config_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_abort;
    logic        sel;

    logic        rdy0, trn0, bsy0, dn0, er0;
    logic        rdy1, trn1, bsy1, dn1, er1;
    logic [68:0] pg0, pg1;

    logic        ready, tile_rst_n, busy, done, err;
    logic [68:0] prog;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  frm[$];
    logic [68:0] exp_prog[2];
    bit          exp_err[2];
    int          hold_len[2];

    always #5 clk = ~clk;

    cb_config_loader #(.SYNC_BYTE(SYNC), .HOLD_CYCLES(2)) dut0 (
        .clb_clk(clk), .rst(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid & ~sel),
        .cfg_ready(rdy0), .cfg_abort(cfg_abort & ~sel), .prog(pg0), .tile_rst_n(trn0),
        .cfg_busy(bsy0), .cfg_done(dn0), .cfg_err(er0)
    );

    cb_config_loader #(.SYNC_BYTE(SYNC), .HOLD_CYCLES(5)) dut1 (
        .clb_clk(clk), .rst(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid & sel),
        .cfg_ready(rdy1), .cfg_abort(cfg_abort & sel), .prog(pg1), .tile_rst_n(trn1),
        .cfg_busy(bsy1), .cfg_done(dn1), .cfg_err(er1)
    );

    assign ready      = sel ? rdy1 : rdy0;
    assign tile_rst_n = sel ? trn1 : trn0;
    assign busy       = sel ? bsy1 : bsy0;
    assign done       = sel ? dn1  : dn0;
    assign err        = sel ? er1  : er0;
    assign prog       = sel ? pg1  : pg0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] noise();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SYNC) b = 8'h5A;
        return b;
    endfunction

    // Drive one byte (called at a negedge); returns how many cycles it waited for ready.
    task automatic send_byte(input logic [7:0] b, output int stalls);
        cfg_data  = b;
        cfg_valid = 1'b1;
        stalls    = 0;
        while (!ready && stalls < 40) begin
            @(negedge clk);
            stalls++;
        end
        if (!ready) check("ready_timeout", ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Frame-level reference: first sync byte starts the frame, 9 payload bytes LSB first, then XOR checksum.
    function automatic void model(output bit good, output logic [68:0] p);
        int          s = 0;
        logic [71:0] acc = '0;
        logic [7:0]  x = '0;
        logic [7:0]  b9;
        while (frm[s] != SYNC) s++;
        for (int k = 1; k <= 9; k++) begin
            acc = acc | (72'(frm[s+k]) << (8 * (k - 1)));
            x   = x ^ frm[s+k];
        end
        b9   = frm[s+9];
        good = (frm[s+10] == x) && (b9 <= 8'h1F);
        p    = acc[68:0];
    endfunction

    task automatic run_frame(input string name);
        bit          good;
        logic [68:0] p;
        int          st;
        int          total = 0;
        int          n;
        model(good, p);
        foreach (frm[i]) begin
            send_byte(frm[i], st);
            total += st;
        end
        check({name, "_no_stall"}, total, 0);
        if (good) begin
            exp_prog[sel] = p;
            exp_err[sel]  = 1'b0;
            check({name, "_prog"}, prog, exp_prog[sel]);
            check({name, "_ready_hold"}, ready, 0);
            check({name, "_busy_hold"}, busy, 1);
            check({name, "_err"}, err, 0);
            n = 0;
            while (tile_rst_n == 1'b0 && n < 40) begin
                cfg_data = noise();
                @(negedge clk);
                n++;
            end
            cfg_valid = 1'b0;
            check({name, "_hold_len"}, n, hold_len[sel]);
            check({name, "_done"}, done, 1);
            check({name, "_ready_after"}, ready, 1);
            @(negedge clk);
            check({name, "_done_pulse"}, done, 0);
            check({name, "_prog_kept"}, prog, exp_prog[sel]);
        end else begin
            cfg_valid    = 1'b0;
            exp_err[sel] = 1'b1;
            check({name, "_err"}, err, 1);
            check({name, "_ready"}, ready, 1);
            check({name, "_busy"}, busy, 0);
            check({name, "_tile_rst"}, tile_rst_n, 1);
            check({name, "_prog_unch"}, prog, exp_prog[sel]);
            @(negedge clk);
            check({name, "_no_done"}, done, 0);
        end
    endtask

    // Random payload; mode 0 good, 1 bad checksum, 2 bad padding. Optional garbage prefix.
    task automatic build_frame(input int mode, input int garbage);
        logic [7:0] x = '0;
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < garbage; i++) frm.push_back(noise());
        frm.push_back(SYNC);
        for (int k = 1; k <= 9; k++) begin
            b = 8'($urandom);
            if (k == 9) b = (mode == 2) ? (b | 8'h20) : (b & 8'h1F);
            frm.push_back(b);
            x ^= b;
        end
        frm.push_back((mode == 1) ? (x ^ (8'd1 << $urandom_range(0, 7))) : x);
    endtask

    task automatic abort_after(input int nbytes);
        int st;
        send_byte(SYNC, st);
        exp_err[sel] = 1'b0;
        for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), st);
        cfg_data  = 8'($urandom);
        cfg_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_prog", prog, exp_prog[sel]);
        check("abort_err", err, exp_err[sel]);
        check("abort_done", done, 0);
        check("abort_ready", ready, 1);
    endtask

    initial begin
        logic [7:0] x;
        int         st;
        hold_len[0] = 2;
        hold_len[1] = 5;
        exp_prog[0] = '0;
        exp_prog[1] = '0;
        exp_err[0]  = 1'b0;
        exp_err[1]  = 1'b0;
        sel       = 1'b0;
        rst_n     = 1'b0;
        cfg_data  = '0;
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        #1;
        check("rst_prog", prog, 0);
        check("rst_ready", ready, 0);
        check("rst_tile", tile_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", ready, 1);
        check("rel_tile", tile_rst_n, 1);

        frm = '{SYNC, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C};
        run_frame("f3c");
        check("f3c_value", prog, 69'h3C);

        frm = '{SYNC, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'h1F};
        run_frame("fones");
        check("fones_value", prog, {69{1'b1}});

        frm = '{SYNC, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'h1E};
        run_frame("fbadchk");

        build_frame(0, 0);
        run_frame("fclear");

        x = 8'h3F;
        frm = '{SYNC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h3F};
        foreach (frm[i]) if (i > 0) x = (i == 9) ? x : x ^ frm[i];
        frm.push_back(x);
        run_frame("fpad");

        frm = '{8'h00, 8'h12, 8'hFF};
        foreach (frm[i]) send_byte(frm[i], st);
        cfg_valid = 1'b0;
        check("garbage_busy", busy, 0);
        abort_after(4);
        build_frame(0, 0);
        run_frame("fafter_abort");

        for (int i = 0; i < 24; i++) begin
            build_frame($urandom_range(0, 2), $urandom_range(0, 3));
            if (i % 8 == 7) abort_after($urandom_range(0, 9));
            run_frame("rnd2");
        end

        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            build_frame((i < 2) ? 0 : $urandom_range(0, 2), $urandom_range(0, 2));
            run_frame("rnd5");
        end

        build_frame(0, 1);
        foreach (frm[i]) send_byte(frm[i], st);
        cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midhold_tile", tile_rst_n, 0);
        rst_n = 1'b0;
        #1;
        exp_prog[0] = '0;
        exp_prog[1] = '0;
        exp_err[0]  = 1'b0;
        exp_err[1]  = 1'b0;
        check("hrst_prog", prog, 0);
        check("hrst_prog0", pg0, 0);
        check("hrst_ready", ready, 0);
        check("hrst_tile", tile_rst_n, 0);
        check("hrst_busy", busy, 0);
        check("hrst_done", done, 0);
        check("hrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hrel_ready", ready, 1);
        check("hrel_tile", tile_rst_n, 1);
        build_frame(0, 0);
        run_frame("final5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
